// File: rtl/uart_rx.sv
// 8N1 UART receiver: recovers bytes from the asynchronous rx line using an
// OVERSAMPLE-times baud tick, sampling each bit at its midpoint.
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        r_state;
    logic          r_sync1;
    logic          r_rx_s;
    logic          r_rx_prev;
    logic [TW-1:0] r_tick_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic [7:0]    r_rx_data;
    logic          r_rx_done;
    logic          r_frame_err;
    logic          r_rx_busy;

    state_t        w_state_nxt;
    logic [TW-1:0] w_tick_nxt;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    w_shift_nxt;
    logic [7:0]    w_data_nxt;
    logic          w_done_nxt;
    logic          w_ferr_nxt;
    logic          w_fall;

    assign w_fall    = r_rx_prev & ~r_rx_s;
    assign rx_data   = r_rx_data;
    assign rx_done   = r_rx_done;
    assign frame_err = r_frame_err;
    assign rx_busy   = r_rx_busy;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_rx_data;
        w_done_nxt  = 1'b0;
        w_ferr_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_tick_nxt = '0;
                w_bit_nxt  = '0;
                if (w_fall) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    if (r_tick_cnt == HALF_LAST) begin
                        w_tick_nxt  = '0;
                        w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    if (r_tick_cnt == FULL_LAST) begin
                        w_tick_nxt  = '0;
                        w_shift_nxt = {r_rx_s, r_shift[7:1]};
                        w_bit_nxt   = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_state_nxt = S_STOP;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    if (r_tick_cnt == FULL_LAST) begin
                        w_tick_nxt  = '0;
                        w_state_nxt = S_IDLE;
                        if (r_rx_s) begin
                            w_data_nxt = r_shift;
                            w_done_nxt = 1'b1;
                        end else begin
                            w_ferr_nxt  = 1'b1;
                            w_shift_nxt = '0;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sync1     <= 1'b1;
            r_rx_s      <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
            r_rx_busy   <= 1'b0;
        end else begin
            r_sync1     <= rx;
            r_rx_s      <= r_sync1;
            r_rx_prev   <= r_rx_s;
            r_state     <= w_state_nxt;
            r_tick_cnt  <= w_tick_nxt;
            r_bit_cnt   <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_rx_data   <= w_data_nxt;
            r_rx_done   <= w_done_nxt;
            r_frame_err <= w_ferr_nxt;
            // Registered from the next state so busy lines up with the state it reports.
            r_rx_busy   <= (w_state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized and scenario bench for uart_rx; a frame-level model predicts the
// bytes and framing errors that the receiver must report.
module tb_uart_rx;

    localparam int OS       = 16;
    localparam int TICK_DIV = 10;
    localparam int BIT_CLK  = OS * TICK_DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    initial begin
        baud_tick = 1'b0;
        forever begin
            repeat (TICK_DIV - 1) @(negedge clk);
            baud_tick = 1'b1;
            @(negedge clk);
            baud_tick = 1'b0;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Observed activity, sampled on the falling edge away from the active edge.
    logic [7:0] got_q[$];
    longint     done_t[$];
    int         ferr_cnt = 0;
    int         both_cnt = 0;
    longint     cyc      = 0;

    always @(negedge clk) begin
        cyc++;
        if (rx_done === 1'b1) begin
            got_q.push_back(rx_data);
            done_t.push_back(cyc);
        end
        if (frame_err === 1'b1) ferr_cnt++;
        if (rx_done === 1'b1 && frame_err === 1'b1) both_cnt++;
    end

    // Reference model: what a correct receiver reports for the frames sent.
    logic [7:0] exp_q[$];
    int         exp_ferr  = 0;
    logic [7:0] last_good = 8'h00;
    int         chk_idx   = 0;

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop_bit);
        if (stop_bit) begin
            exp_q.push_back(b);
            last_good = b;
        end else begin
            exp_ferr++;
        end
    endtask

    task automatic compare(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = chk_idx; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_byte"}, int'(got_q[i]), int'(exp_q[i]));
        check({tag, "_ferr"}, ferr_cnt, exp_ferr);
        check({tag, "_hold"}, int'(rx_data), int'(last_good));
        chk_idx = exp_q.size();
    endtask

    initial begin
        longint t0;
        int     n0;
        logic [7:0] b;
        logic       sb;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_data", int'(rx_data), 0);
        check("rst_done", int'(rx_done), 0);
        check("rst_ferr", int'(frame_err), 0);
        check("rst_busy", int'(rx_busy), 0);
        rst = 1'b0;
        idle_bits(2);

        // Single frame with busy and latency checks.
        t0 = cyc;
        fork
            send_frame(8'h55, 1'b1);
            begin
                repeat (BIT_CLK * 5) @(negedge clk);
                check("single_busy_mid", int'(rx_busy), 1);
            end
        join
        model_frame(8'h55, 1'b1);
        idle_bits(2);
        check("single_busy_after", int'(rx_busy), 0);
        compare("single");
        if (done_t.size() > 0) begin
            // Mid stop bit is 9.5 bit periods after the start edge, plus sync and tick phase.
            check("single_latency_ok",
                  int'((done_t[done_t.size()-1] - t0) >= 1500 &&
                       (done_t[done_t.size()-1] - t0) <= 1540), 1);
        end

        // Back-to-back frames, no idle between.
        n0 = done_t.size();
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        model_frame(8'hA3, 1'b1);
        model_frame(8'h0F, 1'b1);
        idle_bits(2);
        compare("b2b");
        if (done_t.size() == n0 + 2)
            check("b2b_spacing", int'(done_t[n0+1] - done_t[n0]), 10 * BIT_CLK);
        else
            check("b2b_pulses", done_t.size() - n0, 2);

        // Glitch: 4 ticks low then high must not start a frame.
        rx = 1'b0;
        repeat (4 * TICK_DIV) @(negedge clk);
        idle_bits(2);
        check("glitch_busy", int'(rx_busy), 0);
        compare("glitch");

        // Framing error, then a good frame.
        send_frame(8'h3C, 1'b0);
        model_frame(8'h3C, 1'b0);
        idle_bits(2);
        compare("ferr");
        send_frame(8'h81, 1'b1);
        model_frame(8'h81, 1'b1);
        idle_bits(2);
        compare("after_ferr");

        // Reset during bit 4 of 0xFF drops the frame.
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (BIT_CLK * 5 + BIT_CLK / 2) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                check("midrst_data", int'(rx_data), 0);
                check("midrst_done", int'(rx_done), 0);
                check("midrst_ferr", int'(frame_err), 0);
                check("midrst_busy", int'(rx_busy), 0);
                rst = 1'b0;
            end
        join
        last_good = 8'h00;
        idle_bits(2);
        compare("midrst");
        send_frame(8'hC5, 1'b1);
        model_frame(8'hC5, 1'b1);
        idle_bits(2);
        compare("after_midrst");

        // Line held low through reset release. The synchronizer leaves reset at 1, so
        // release creates one edge; that frame reads all zeros and ends in a framing error.
        rx  = 1'b0;
        rst = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        exp_ferr++;
        repeat (3 * 10 * BIT_CLK) @(negedge clk);
        compare("break");
        idle_bits(2);
        send_frame(8'h7E, 1'b1);
        model_frame(8'h7E, 1'b1);
        idle_bits(2);
        compare("after_break");

        // Randomized traffic: random bytes, gaps (including none) and bad stop bits.
        for (int k = 0; k < 16; k++) begin
            b  = 8'($urandom);
            sb = ($urandom_range(0, 4) != 0);
            send_frame(b, sb);
            model_frame(b, sb);
            if (!sb || $urandom_range(0, 2) != 0) begin
                idle_bits(1);
                repeat ($urandom_range(0, BIT_CLK - 1)) @(negedge clk);
            end
        end
        idle_bits(2);
        compare("rand");

        check("never_both", both_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
